// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared definitions for the VGA timing generator: pattern mode
//               encodings, bar colours and timing/parameter helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_EXT    = 2'd0;
  localparam mode_t MODE_BORDER = 2'd1;
  localparam mode_t MODE_BARS   = 2'd2;
  localparam mode_t MODE_GRID   = 2'd3;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  // Colour of bar idx, left to right across the active area.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

  // Total line length (clocks) or frame height (lines).
  function automatic int unsigned frame_total(input int unsigned sync,
                                              input int unsigned back,
                                              input int unsigned active,
                                              input int unsigned front);
    return sync + back + active + front;
  endfunction

  // True when a counter of 'width' bits can hold 0..total-1.
  function automatic bit counter_fits(input int unsigned total,
                                      input int unsigned width);
    return (width >= 32) || ((64'd1 << width) > (64'(total) - 64'd1));
  endfunction

  // RGB may lead the data-enable by 0 or 1 clocks only.
  function automatic bit lead_legal(input int unsigned lead);
    return lead <= 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_pattern.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_gen
// Description : Selects the pixel colour (external data, border, colour bars
//               or grid) and registers it; forced to black when not enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned CW       = 8,
  parameter int unsigned HW       = 11,
  parameter int unsigned VW       = 10,
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned V_ACTIVE = 768
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  mode_t           mode,
  input  logic [HW-1:0]   pix_x,
  input  logic [VW-1:0]   pix_y,
  input  logic [3*CW-1:0] pix_in,
  output logic [3*CW-1:0] rgb
);

  // Last bar takes whatever H_ACTIVE/8 leaves over.
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  // Pattern colours are saturated per channel, so one bit per channel suffices.
  function automatic logic [3*CW-1:0] expand(input logic [23:0] c);
    return {{CW{c[23]}}, {CW{c[15]}}, {CW{c[7]}}};
  endfunction

  logic [31:0]     x32;
  logic [31:0]     y32;
  logic [2:0]      bar;
  logic [23:0]     colour;
  logic [3*CW-1:0] rgb_next;

  // Colour of the current pixel for the latched mode.
  always_comb begin
    x32 = 32'(pix_x);
    y32 = 32'(pix_y);
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x32 >= 32'(i) * BAR_W) bar = 3'(i);
    end
    colour = COL_BLACK;
    case (mode)
      MODE_BORDER: begin
        if (x32 == 32'd0 || x32 == H_ACTIVE - 1)      colour = COL_RED;
        else if (y32 == 32'd0 || y32 == V_ACTIVE - 1) colour = COL_GREEN;
        else                                          colour = COL_WHITE;
      end
      MODE_BARS: colour = bar_colour(bar);
      MODE_GRID: colour = (x32[4:0] == 5'd0 || y32[4:0] == 5'd0) ? COL_WHITE : COL_BLACK;
      default:   colour = COL_BLACK;
    endcase
    rgb_next = (mode == MODE_EXT) ? pix_in : expand(colour);
  end

  // Output register; black outside the requested pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rgb <= '0;
    else if (en) rgb <= rgb_next;
    else         rgb <= '0;
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA/DVI-DAC timing generator with pixel-request
//               look-ahead, test-pattern engine and RGB lead alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC    = 136,
  parameter int unsigned H_BACK    = 160,
  parameter int unsigned H_ACTIVE  = 1024,
  parameter int unsigned H_FRONT   = 24,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BACK    = 29,
  parameter int unsigned V_ACTIVE  = 768,
  parameter int unsigned V_FRONT   = 3,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned DATA_LEAD = 1,
  parameter int unsigned CW        = 8,
  parameter int unsigned HW        = 11,
  parameter int unsigned VW        = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] pix_in,
  output logic            pix_req,
  output logic [HW-1:0]   pix_x,
  output logic [VW-1:0]   pix_y,
  output logic [CW-1:0]   vga_r,
  output logic [CW-1:0]   vga_g,
  output logic [CW-1:0]   vga_b,
  output logic            vga_hs,
  output logic            vga_vs,
  output logic            vga_de,
  output logic            vga_blank_n,
  output logic            vga_sync,
  output logic            vga_clk,
  output logic            frame_start,
  output logic            line_start
);

  localparam int unsigned H_TOTAL = frame_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int unsigned V_TOTAL = frame_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
  localparam int unsigned H_START = H_SYNC + H_BACK;
  localparam int unsigned H_END   = H_START + H_ACTIVE;
  localparam int unsigned V_START = V_SYNC + V_BACK;
  localparam int unsigned V_END   = V_START + V_ACTIVE;
  // Requests run ahead of the counter: one clock for the upstream read, one
  // for the pattern register, plus the RGB lead.
  localparam int unsigned REQ_OFF = DATA_LEAD + 2;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  generate
    if (!counter_fits(H_TOTAL, HW)) begin : g_chk_hw
      $error("vga_timing_gen: HW too narrow for H_TOTAL");
    end
    if (!counter_fits(V_TOTAL, VW)) begin : g_chk_vw
      $error("vga_timing_gen: VW too narrow for V_TOTAL");
    end
    if (!lead_legal(DATA_LEAD)) begin : g_chk_lead
      $error("vga_timing_gen: DATA_LEAD must be 0 or 1");
    end
    // Look-ahead must stay inside the current line's blanking.
    if (H_START < REQ_OFF) begin : g_chk_ahead
      $error("vga_timing_gen: H_SYNC+H_BACK too short for request look-ahead");
    end
  endgenerate

  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic [31:0]     h_now;
  logic [31:0]     h_ahead;
  logic [31:0]     v_now;
  logic            h_act;
  logic            h_req_act;
  logic            v_act;
  mode_t           mode_q;
  logic            req_d;
  logic [HW-1:0]   x_d;
  logic [VW-1:0]   y_d;
  logic [3*CW-1:0] rgb;

  // Region decode of the current and look-ahead counter positions.
  always_comb begin
    h_now     = 32'(h_cnt);
    v_now     = 32'(v_cnt);
    h_ahead   = h_now + REQ_OFF;
    h_act     = (h_now >= H_START) && (h_now < H_END);
    h_req_act = (h_ahead >= H_START) && (h_ahead < H_END);
    v_act     = (v_now >= V_START) && (v_now < V_END);
  end

  // Horizontal/vertical position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Registered syncs, enables, strobes, pixel request and mode latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
      vga_de      <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      mode_q      <= MODE_EXT;
    end else begin
      vga_hs      <= (h_now < H_SYNC) ? HS_POL : ~HS_POL;
      vga_vs      <= (v_now < V_SYNC) ? VS_POL : ~VS_POL;
      vga_de      <= h_act && v_act;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      line_start  <= (h_cnt == '0);
      pix_req     <= h_req_act && v_act;
      pix_x       <= (h_req_act && v_act) ? HW'(h_ahead - H_START) : '0;
      pix_y       <= (h_req_act && v_act) ? VW'(v_now - V_START) : '0;
      if ((h_cnt == '0) && (v_cnt == '0)) mode_q <= mode;
    end
  end

  // Align request coordinates with the returning upstream pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d       <= 1'b0;
      x_d         <= '0;
      y_d         <= '0;
      vga_blank_n <= 1'b0;
    end else begin
      req_d       <= pix_req;
      x_d         <= pix_x;
      y_d         <= pix_y;
      vga_blank_n <= req_d;
    end
  end

  vga_pattern_gen #(
    .CW       (CW),
    .HW       (HW),
    .VW       (VW),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pattern (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (req_d),
    .mode   (mode_q),
    .pix_x  (x_d),
    .pix_y  (y_d),
    .pix_in (pix_in),
    .rgb    (rgb)
  );

  assign {vga_r, vga_g, vga_b} = rgb;
  assign vga_sync = 1'b0;
  assign vga_clk  = ~clk;

endmodule
`default_nettype wire
